// File: rtl/pixel_stream_fetch.sv
// Memory-to-channel fetch buffer: sequential frame reads into a small FIFO,
// head word handed to NUM_CH channels in round-robin or broadcast fashion.
module pixel_stream_fetch #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned NUM_ADDRS = 115200,
  parameter int unsigned ADDR_W    = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     restart,
  input  logic                     bcast,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_rts,
  output logic                     in_rtr,
  output logic [ADDR_W-1:0]        mem_ptr,
  output logic [DATA_W-1:0]        out_data,
  output logic [NUM_CH-1:0]        out_rts,
  input  logic [NUM_CH-1:0]        out_rtr,
  output logic                     frame_done,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W = PTR_W - 1;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_BCAST = 1'b1
  } mode_t;

  logic [DATA_W-1:0] queue [DEPTH];

  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [ADDR_W-1:0] mem_ptr_q, mem_ptr_d;
  logic [NUM_CH-1:0] ch_sel_q, ch_sel_d;
  logic [NUM_CH-1:0] served_q, served_d;
  mode_t             mode_q, mode_d;
  logic              frame_done_q, frame_done_d;

  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              last_addr;
  logic [NUM_CH-1:0] xfc;
  logic [NUM_CH-1:0] served_merge;

  // The extra wrap bit distinguishes full from empty when the indices match.
  assign empty = (rd_q == wr_q);
  assign full  = (rd_q[IDX_W-1:0] == wr_q[IDX_W-1:0]) && (rd_q[PTR_W-1] != wr_q[PTR_W-1]);

  assign in_rtr     = ~full;
  assign level      = wr_q - rd_q;
  assign mem_ptr    = mem_ptr_q;
  assign frame_done = frame_done_q;
  assign out_data   = queue[rd_q[IDX_W-1:0]];

  always_comb begin
    if (mode_q == MODE_BCAST) begin
      out_rts = {NUM_CH{~empty}} & ~served_q;
    end else begin
      out_rts = {NUM_CH{~empty}} & ch_sel_q;
    end
  end

  assign xfc          = out_rts & out_rtr;
  assign served_merge = served_q | xfc;
  assign last_addr    = (mem_ptr_q == ADDR_W'(NUM_ADDRS - 1));

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    rd_d         = rd_q;
    wr_d         = wr_q;
    mem_ptr_d    = mem_ptr_q;
    ch_sel_d     = ch_sel_q;
    served_d     = served_q;
    mode_d       = mode_q;
    frame_done_d = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;

    if (restart) begin
      rd_d      = '0;
      wr_d      = '0;
      mem_ptr_d = '0;
      served_d  = '0;
      ch_sel_d  = NUM_CH'(1);
      mode_d    = mode_t'(bcast);
    end else begin
      push = in_rts & ~full;

      if (mode_q == MODE_RR) begin
        pop = |(xfc & ch_sel_q);
        if (pop) begin
          ch_sel_d = (ch_sel_q << 1) | (ch_sel_q >> (NUM_CH - 1));
        end
      end else if (|xfc) begin
        // The head word retires only once every channel has taken it.
        if (&served_merge) begin
          pop      = 1'b1;
          served_d = '0;
        end else begin
          served_d = served_merge;
        end
      end

      if (push) begin
        wr_d         = wr_q + PTR_W'(1);
        mem_ptr_d    = last_addr ? '0 : mem_ptr_q + ADDR_W'(1);
        frame_done_d = last_addr;
      end

      if (pop) begin
        rd_d = rd_q + PTR_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q         <= '0;
      wr_q         <= '0;
      mem_ptr_q    <= '0;
      ch_sel_q     <= NUM_CH'(1);
      served_q     <= '0;
      mode_q       <= MODE_RR;
      frame_done_q <= 1'b0;
    end else begin
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      mem_ptr_q    <= mem_ptr_d;
      ch_sel_q     <= ch_sel_d;
      served_q     <= served_d;
      mode_q       <= mode_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: queue storage has no reset; its contents are only observed behind
  // the pointers, which are reset.
  always_ff @(posedge clk) begin
    if (push) begin
      queue[wr_q[IDX_W-1:0]] <= in_data;
    end
  end

endmodule

// File: tb/tb_pixel_stream_fetch.sv
// Directed bench for pixel_stream_fetch with a short frame (NUM_ADDRS=5) so
// the mem_ptr wrap and frame_done pulse are reachable quickly.
module tb_pixel_stream_fetch;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned NUM_CH    = 3;
  localparam int unsigned NUM_ADDRS = 5;
  localparam int unsigned ADDR_W    = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              restart;
  logic              bcast;
  logic [DATA_W-1:0] in_data;
  logic              in_rts;
  logic              in_rtr;
  logic [ADDR_W-1:0] mem_ptr;
  logic [DATA_W-1:0] out_data;
  logic [NUM_CH-1:0] out_rts;
  logic [NUM_CH-1:0] out_rtr;
  logic              frame_done;
  logic [2:0]        level;

  int errors = 0;
  int checks = 0;

  pixel_stream_fetch #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .NUM_CH   (NUM_CH),
    .NUM_ADDRS(NUM_ADDRS),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
    .bcast     (bcast),
    .in_data   (in_data),
    .in_rts    (in_rts),
    .in_rtr    (in_rtr),
    .mem_ptr   (mem_ptr),
    .out_data  (out_data),
    .out_rts   (out_rts),
    .out_rtr   (out_rtr),
    .frame_done(frame_done),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle, so outputs reflect the new state.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    restart = 1'b0;
    bcast   = 1'b0;
    in_data = '0;
    in_rts  = 1'b0;
    out_rtr = '0;
    step();
    step();

    // Reset state
    check("rst_in_rtr", in_rtr, 1);
    check("rst_out_rts", out_rts, 0);
    check("rst_mem_ptr", mem_ptr, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_level", level, 0);
    rst = 1'b0;

    // Fill with all channels stalled
    in_rts = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 32'h100 + k;
      step();
      check("fill_level", level, k + 1);
      check("fill_out_rts", out_rts, 3'b001);
    end
    check("fill_in_rtr", in_rtr, 0);
    check("fill_mem_ptr", mem_ptr, 4);
    check("fill_head", out_data, 32'h100);
    in_data = 32'h1FF;
    step();
    check("full_hold_level", level, 4);
    check("full_hold_mem_ptr", mem_ptr, 4);

    // Full with simultaneous pop: no rtr-through, refill next cycle
    out_rtr = 3'b111;
    check("full_pop_in_rtr_pre", in_rtr, 0);
    step();
    check("full_pop_level", level, 3);
    check("full_pop_in_rtr", in_rtr, 1);
    check("full_pop_out_rts", out_rts, 3'b010);
    check("full_pop_head", out_data, 32'h101);
    check("full_pop_mem_ptr", mem_ptr, 4);
    out_rtr = 3'b000;
    in_data = 32'h200;
    step();
    check("refill_level", level, 4);
    check("refill_wrap_mem_ptr", mem_ptr, 0);
    check("refill_frame_done", frame_done, 1);
    in_rts = 1'b0;
    step();
    check("frame_done_pulse_end", frame_done, 0);

    // Restart in round-robin mode; transfers in that cycle are ignored
    restart = 1'b1;
    bcast   = 1'b0;
    in_rts  = 1'b1;
    in_data = 32'hDEAD;
    out_rtr = 3'b111;
    step();
    check("restart_level", level, 0);
    check("restart_out_rts", out_rts, 0);
    check("restart_mem_ptr", mem_ptr, 0);
    check("restart_in_rtr", in_rtr, 1);
    restart = 1'b0;

    // Round-robin order A,B,C,D with all channels ready
    in_data = 32'hA; step();
    check("rr_a_rts", out_rts, 3'b001); check("rr_a_data", out_data, 32'hA);
    in_data = 32'hB; step();
    check("rr_b_rts", out_rts, 3'b010); check("rr_b_data", out_data, 32'hB);
    check("rr_b_level", level, 1);
    in_data = 32'hC; step();
    check("rr_c_rts", out_rts, 3'b100); check("rr_c_data", out_data, 32'hC);
    in_data = 32'hD; step();
    check("rr_d_rts", out_rts, 3'b001); check("rr_d_data", out_data, 32'hD);
    in_rts = 1'b0;
    step();
    check("rr_drain_level", level, 0);
    check("rr_drain_out_rts", out_rts, 0);
    check("rr_mem_ptr", mem_ptr, 4);

    // Mid-operation restart with level=3 and ch_sel=010
    out_rtr = 3'b000;
    in_rts  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 32'hE0 + k;
      step();
    end
    check("pre_restart_level", level, 3);
    check("pre_restart_out_rts", out_rts, 3'b010);
    check("pre_restart_mem_ptr", mem_ptr, 2);
    restart = 1'b1;
    in_data = 32'hDEAD;
    out_rtr = 3'b111;
    step();
    check("mid_restart_level", level, 0);
    check("mid_restart_out_rts", out_rts, 0);
    check("mid_restart_mem_ptr", mem_ptr, 0);
    restart = 1'b0;

    // Frame wrap over 7 words; also confirms ch_sel restarted at 001
    for (int k = 1; k <= 7; k++) begin
      in_data = 32'h300 + k;
      step();
      check("wrap_mem_ptr", mem_ptr, k % 5);
      check("wrap_frame_done", frame_done, (k == 5) ? 1 : 0);
      check("wrap_out_rts", out_rts, 3'b001 << ((k - 1) % 3));
      check("wrap_data", out_data, 32'h300 + k);
      check("wrap_level", level, 1);
    end
    in_rts = 1'b0;
    step();
    check("wrap_drain_level", level, 0);

    // Broadcast stagger; bcast drops after restart but mode must stick
    restart = 1'b1;
    bcast   = 1'b1;
    out_rtr = 3'b000;
    step();
    restart = 1'b0;
    bcast   = 1'b0;
    in_rts  = 1'b1;
    in_data = 32'h57;
    step();
    in_rts = 1'b0;
    check("bc_rts0", out_rts, 3'b111);
    check("bc_level0", level, 1);
    out_rtr = 3'b010; step();
    check("bc_rts1", out_rts, 3'b101);
    check("bc_level1", level, 1);
    check("bc_data1", out_data, 32'h57);
    out_rtr = 3'b000; step();
    check("bc_rts2", out_rts, 3'b101);
    out_rtr = 3'b101; step();
    check("bc_rts3", out_rts, 3'b000);
    check("bc_level3", level, 0);

    // Broadcast throughput with every channel ready
    out_rtr = 3'b111;
    in_rts  = 1'b1;
    in_data = 32'h61; step();
    check("bc_tp_x_rts", out_rts, 3'b111); check("bc_tp_x_data", out_data, 32'h61);
    in_data = 32'h62; step();
    check("bc_tp_y_rts", out_rts, 3'b111); check("bc_tp_y_data", out_data, 32'h62);
    check("bc_tp_level", level, 1);
    in_rts = 1'b0;
    step();
    check("bc_tp_drain", level, 0);

    // Asynchronous reset asserted mid-cycle
    out_rtr = 3'b000;
    in_rts  = 1'b1;
    in_data = 32'h70;
    step();
    in_rts = 1'b0;
    check("pre_arst_level", level, 1);
    check("pre_arst_mem_ptr", mem_ptr, 4);
    #3 rst = 1'b1;
    #1;
    check("arst_level", level, 0);
    check("arst_out_rts", out_rts, 0);
    check("arst_in_rtr", in_rtr, 1);
    check("arst_mem_ptr", mem_ptr, 0);
    #1 rst = 1'b0;
    in_rts  = 1'b1;
    in_data = 32'h77;
    step();
    in_rts = 1'b0;
    check("post_arst_rr_mode", out_rts, 3'b001);
    check("post_arst_data", out_data, 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_stream_fetch.md
# pixel_stream_fetch

Parametrised memory-to-channel fetch buffer. Reads sequential words from frame memory through an address pointer, holds them in a DEPTH-entry FIFO, and distributes them to NUM_CH downstream colour/plane channels. In round-robin mode each word goes to one channel in rotation; in broadcast mode each word goes to all channels. The block sits between the frame-buffer read port and the per-channel pixel pipelines.

## Interface
- DATA_W, 32, word width
- DEPTH, 4, FIFO entries; power of two, at least 2
- NUM_CH, 3, output channel count, 1..8
- NUM_ADDRS, 115200, words per frame; mem_ptr wraps at this count
- ADDR_W, 17, mem_ptr width; must satisfy 2^ADDR_W >= NUM_ADDRS
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- restart  in  1  synchronous frame restart; also loads the mode register from bcast
- bcast  in  1  mode select: 0 = round-robin, 1 = broadcast; sampled only on restart
- in_data  in  DATA_W  memory read data
- in_rts  in  1  memory data valid
- in_rtr  out  1  ready to accept a word
- mem_ptr  out  ADDR_W  address of the next word to fetch
- out_data  out  DATA_W  FIFO head word, shared by all channels
- out_rts  out  NUM_CH  per-channel valid
- out_rtr  in  NUM_CH  per-channel ready
- frame_done  out  1  one-cycle pulse after the last word of a frame is accepted
- level  out  clog2(DEPTH)+1  FIFO occupancy

## Operation
- Transfer rules: in_xfc = in_rts & in_rtr. Channel i transfers (xfc[i]) when out_rts[i] & out_rtr[i].
- FIFO pointers:
  - rd and wr pointers are clog2(DEPTH)+1 bits, with an extra wrap bit.
  - empty when rd == wr; full when the low bits are equal and the MSBs differ.
  - level = wr - rd, modulo 2^(clog2(DEPTH)+1).
- in_rtr = ~full.
- On in_xfc:
  - write queue[wr low bits] and increment wr.
  - mem_ptr advances by 1; from NUM_ADDRS-1 it goes to 0 instead.
  - the wrap sets frame_done for the next cycle.
- out_data = queue[rd low bits]. It is don't-care while empty.
- Round-robin mode (mode = 0):
  - ch_sel is one-hot and resets to bit 0.
  - out_rts = {NUM_CH{~empty}} & ch_sel.
  - On xfc of the selected channel, increment rd and rotate ch_sel left; bit NUM_CH-1 wraps to bit 0.
  - out_rtr of unselected channels is ignored.
- Broadcast mode (mode = 1):
  - served is an NUM_CH-bit register; out_rts[i] = ~empty & ~served[i].
  - On any xfc, let served_next = served | xfc.
  - If served_next is all ones: increment rd and clear served.
  - Otherwise: served <= served_next.
  - Any subset of channels may transfer in the same cycle.
- Simultaneous push and pop: both happen; level is unchanged.
  - A full FIFO keeps in_rtr = 0 even in a pop cycle; there is no combinational rtr-through.
  - An empty FIFO does not forward the word; it becomes visible the next cycle.
- restart:
  - Takes priority over all transfers in that cycle; no write and no pop occur.
  - Clears rd, wr, mem_ptr, served and frame_done; sets ch_sel = 1; mode <= bcast.
  - Stored queue data is not cleared.
- rst: asynchronously forces the same values as restart, with mode = 0.
  - Takes effect mid-transfer; any in-flight word is discarded.
- Reset values of outputs: in_rtr=1, out_rts=0, mem_ptr=0, frame_done=0, level=0, out_data=don't-care. Queue storage is not reset.

## Timing
- All state is registered.
- in_rtr, out_rts, level and out_data depend on registers only; there is no combinational path from in_rts or out_rtr to any output.
- Latency from in_xfc to out_rts asserted: 1 cycle.
- Throughput:
  - Round-robin: 1 word per cycle in and 1 channel-transfer per cycle out.
  - Broadcast: 1 word per cycle if all channels are ready every cycle.
- mem_ptr updates on the edge after in_xfc.
- frame_done is high for exactly the one cycle following the accepting edge of word NUM_ADDRS-1.
- restart asserted for N cycles holds the cleared state for N cycles. Operation resumes on the first edge after deassertion.

## Test plan
- Reset then fill. Defaults DEPTH=4, NUM_CH=3.
  - Stimulus: rst pulse, then in_rts=1 with all out_rtr=0.
  - Required: four words accepted; in_rtr=0 from cycle 5; level=4; mem_ptr=4; out_rts=001.
- Round-robin order. Mode 0, all out_rtr=1, words A,B,C,D streamed.
  - Required: ch0=A, ch1=B, ch2=C, ch0=D.
  - out_rts sequence is 001, 010, 100, 001; no word is skipped or duplicated.
- Broadcast stagger. restart with bcast=1; one word W.
  - Stimulus: ch1 ready in cycle 1, ch0 and ch2 ready in cycle 3.
  - Required: out_rts goes 111 → 101 → 000; rd increments exactly once, after cycle 3; level goes 1 → 0.
- Frame wrap. NUM_ADDRS=5, stream 7 words.
  - Required: mem_ptr runs 0,1,2,3,4,0,1,2; frame_done pulses exactly one cycle, after the 5th accept.
- Full plus simultaneous pop. FIFO full; one channel pops while in_rts=1.
  - Required: in_rtr stays 0 in that cycle; the next cycle in_rtr=1; level goes 4 → 3 → 4 after refill.
- Mid-operation restart and rst. level=3, ch_sel=010, restart asserted for 1 cycle.
  - Required: level=0, out_rts=0, mem_ptr=0, ch_sel=001; in_xfc/out xfc in the restart cycle has no effect.
  - Repeat with async rst asserted mid-cycle: outputs clear immediately, without waiting for a clock edge.
